fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/fp_mul_arbiter.sv | 80 ++++++++
 tb/tb_fp_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and defaults for the round-robin front end of a pipelined FP multiplier.
package fp_mul_pkg;

  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 2;
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [ID_W-1:0] req_id_t;

  // One in-flight operation: which requester the multiplier result belongs to.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last granted index has top priority.
module rr_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  req_i,
  input  logic          xfer_i,
  output logic [N-1:0]  grant_o,
  output req_id_t       grant_id_o
);

  req_id_t       last_q;
  req_id_t       last_d;
  logic          found;
  logic [ID_W:0] sum;
  req_id_t       idx;

  // Scan starting one past the last grant, wrapping modulo N.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int off = 1; off <= N; off++) begin
      sum = {1'b0, last_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      idx = sum[ID_W-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        grant_o    = '0;
        grant_o[idx] = 1'b1;
        grant_id_o = idx;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (xfer_i) last_d = grant_id_o;
  end

  // Reset value N-1 gives requester 0 the highest priority.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) last_q <= req_id_t'(N-1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters; results are routed back by tag.
module fp_mul_arbiter #(
  parameter int NUM_REQ     = fp_mul_pkg::NUM_REQ,
  parameter int MUL_LATENCY = fp_mul_pkg::MUL_LATENCY
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic [31:0]              mul_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     busy
);
  import fp_mul_pkg::*;

  // Handshake: an operation transfers on the rising edge where req_valid[i] && req_ready[i];
  // req_ready is derived only from req_valid, en and the pointer, never from itself.
  // Responses carry no ready: rsp_valid[i] is a one-cycle strobe that must be accepted.

  logic               en_eff;
  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_id;
  logic               xfer;
  tag_t               tag_d;
  tag_t               tag_q [MUL_LATENCY];
  tag_t               tag_last;

  // Gating with nreset keeps grants and operands quiet while reset is held.
  assign en_eff    = en & nreset;
  assign req_gated = req_valid & {NUM_REQ{en_eff}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk        (clk),
    .nreset     (nreset),
    .req_i      (req_gated),
    .xfer_i     (xfer),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign xfer      = |(grant & req_valid);
  assign req_ready = grant;
  assign mul_a     = xfer ? req_a[grant_id] : 32'h0;
  assign mul_b     = xfer ? req_b[grant_id] : 32'h0;

  always_comb begin
    tag_d.valid = xfer;
    tag_d.id    = xfer ? grant_id : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < MUL_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_last = tag_q[MUL_LATENCY-1];
  assign rsp_data = tag_last.valid ? mul_result : 32'h0;

  always_comb begin
    rsp_valid = '0;
    if (tag_last.valid) rsp_valid[tag_last.id] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) busy = busy | tag_q[i].valid;
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized scoreboard bench for fp_mul_arbiter with a latency-matched multiplier stub.
module tb_fp_mul_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 50;  // {due cycle[15:0], id[1:0], data[31:0]}

  logic                clk = 1'b0;
  logic                nreset = 1'b0;
  logic                en = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][31:0]  req_a = '0;
  logic [N-1:0][31:0]  req_b = '0;
  logic [N-1:0]        req_ready;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [31:0]         mul_result;
  logic [N-1:0]        rsp_valid;
  logic [31:0]         rsp_data;
  logic                busy;

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .en         (en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference functions ----------------
  // Single-precision multiply for normal operands (truncating); exact for simple products.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    ex = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom_range(0, 32'h7FFFFF))};
  endfunction

  // ---------------- multiplier stub: L-stage pipeline ----------------
  logic [31:0] mul_pipe [L];
  always @(posedge clk) begin
    mul_pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < L; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[L-1];

  // ---------------- model state and scoreboard ----------------
  logic [N-1:0]       exp_ready = '0;
  logic [31:0]        exp_mul_a = '0;
  logic [31:0]        exp_mul_b = '0;
  int                 last_g = N-1;
  logic [W-1:0]       exp_q[$];
  logic [N-1:0][31:0] op_a = '0;
  logic [N-1:0][31:0] op_b = '0;
  int                 n_pass = 0;
  int                 n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_fp();
      op_b[i] = rand_fp();
    end
  endtask

  task automatic drive_cycle(input logic en_v, input logic [N-1:0] v);
    int           g;
    logic [1:0]   gi;
    logic [N-1:0] one;
    @(posedge clk);
    #1;
    nreset    = 1'b1;
    en        = en_v;
    req_valid = v;
    req_a     = op_a;
    req_b     = op_b;
    one       = 1;
    g         = en_v ? rr_pick(v, last_g) : -1;
    if (g >= 0) begin
      gi        = 2'(g);
      exp_ready = one << g;
      exp_mul_a = op_a[gi];
      exp_mul_b = op_b[gi];
      exp_q.push_back({16'(cyc + L), gi, fmul(op_a[gi], op_b[gi])});
      last_g    = g;
    end else begin
      exp_ready = '0;
      exp_mul_a = '0;
      exp_mul_b = '0;
    end
  endtask

  // Holds reset for n cycles; the next drive_cycle releases it.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    nreset    = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    exp_q.delete();
    last_g    = N-1;
    exp_ready = '0;
    exp_mul_a = '0;
    exp_mul_b = '0;
    repeat (n-1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b1, '0);
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0]  m_f;
  logic          m_busy;
  logic [N-1:0]  m_rv;
  logic [31:0]   m_rd;

  always @(negedge clk) begin
    m_busy = 1'b0;
    foreach (exp_q[i]) if (int'(exp_q[i][W-1 -: 16]) - L < cyc) m_busy = 1'b1;
    m_rv = '0;
    m_rd = '0;
    if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 16]) == cyc) begin
      m_f = exp_q.pop_front();
      m_rv[m_f[33:32]] = 1'b1;
      m_rd = m_f[31:0];
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("mul_a",     64'(mul_a),     64'(exp_mul_a));
    check("mul_b",     64'(mul_b),     64'(exp_mul_b));
    check("busy",      64'(busy),      64'(m_busy));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("rsp_data",  64'(rsp_data),  64'(m_rd));
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);

    // 1.0 * 2.0 from requester 0
    op_a[0] = 32'h3F800000;
    op_b[0] = 32'h40000000;
    drive_cycle(1'b1, 4'b0001);
    idle(4);

    // all four requesters contend for 8 cycles
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      drive_cycle(1'b1, 4'b1111);
    end
    idle(4);

    // lone requester 2 at full throughput
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      drive_cycle(1'b1, 4'b0100);
    end
    idle(4);

    // issue to 1 and 3, then drop en while they keep requesting
    do_reset(1);
    rand_ops();
    drive_cycle(1'b1, 4'b1010);
    drive_cycle(1'b1, 4'b1010);
    repeat (5) drive_cycle(1'b0, 4'b1010);
    idle(2);

    // reset in the middle of three in-flight operations
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      drive_cycle(1'b1, 4'b1111);
    end
    do_reset(1);
    rand_ops();
    drive_cycle(1'b1, 4'b1111);
    idle(4);

    // pointer at 3 with requesters 0 and 3 valid
    do_reset(1);
    rand_ops();
    drive_cycle(1'b1, 4'b1000);
    drive_cycle(1'b1, 4'b1001);
    drive_cycle(1'b1, 4'b1001);
    idle(4);

    // random traffic with occasional en drops and resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        rand_ops();
        drive_cycle(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)));
      end
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
